boot_sequencer: RTL and testbench

- Controls the iCE40 SB_WARMBOOT primitive in the USB bootloader.
- Watches the SOF stream from usb_fs_pe and tracks host presence.
- Accepts boot requests from the SPI bridge endpoint, or raises one itself when the host is absent too long.
- Holds off the warm boot until flash traffic and the final USB handshake have finished, then drives stable S1/S0 before BOOT.
- Also drives the RGB status PWM inputs.

---
 rtl/boot_pkg.sv | 23 ++
 rtl/sof_lock_detector.sv | 63 ++++++
 rtl/boot_sequencer.sv | 117 +++++++++++
 tb/tb_boot_sequencer.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/boot_pkg.sv
// Shared types and constants for the warm-boot sequencer and its SOF lock detector.
package boot_pkg;

    typedef enum logic [1:0] {
        StWaitHost = 2'd0,
        StHostOk   = 2'd1,
        StArm      = 2'd2,
        StFire     = 2'd3
    } boot_state_e;

    localparam logic [1:0] IMG_BOOTLOADER = 2'd0;
    localparam logic [1:0] IMG_USER0      = 2'd1;
    localparam logic [1:0] IMG_USER1      = 2'd2;
    localparam logic [1:0] IMG_USER2      = 2'd3;

    localparam int unsigned FrameW = 11;

    // USB frame numbers are 11 bits, so 2047 -> 0 wraps naturally.
    function automatic logic [FrameW-1:0] next_frame(input logic [FrameW-1:0] idx);
        return idx + 11'd1;
    endfunction

endpackage

// File: rtl/sof_lock_detector.sv
// Tracks time since the last SOF and locks onto a run of well-spaced, consecutive frames.
module sof_lock_detector
    import boot_pkg::*;
#(
    parameter int unsigned SOF_GAP_CYCLES = 72000,
    parameter int unsigned SOF_LOCK_COUNT = 3
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sof_valid_i,
    input  logic [FrameW-1:0] frame_index_i,
    output logic [31:0]       timer_o,
    output logic              host_present_o
);

    localparam logic [1:0] LockMax = SOF_LOCK_COUNT[1:0];

    logic [31:0]       timer_q, timer_d;
    logic [1:0]        lock_q, lock_d;
    logic [FrameW-1:0] last_q, last_d;
    logic              sof_good;

    always_comb begin
        timer_d  = timer_q;
        lock_d   = lock_q;
        last_d   = last_q;
        sof_good = (timer_q <= SOF_GAP_CYCLES) && (frame_index_i == next_frame(last_q));

        if (sof_valid_i) begin
            timer_d = '0;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 32'd1;
        end

        // A SOF arriving after a long gap restarts the run at 1 rather than clearing it.
        if (sof_valid_i) begin
            last_d = frame_index_i;
            if (sof_good) begin
                lock_d = (lock_q == LockMax) ? LockMax : lock_q + 2'd1;
            end else begin
                lock_d = 2'd1;
            end
        end else if (timer_q > SOF_GAP_CYCLES) begin
            lock_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timer_q <= '0;
            lock_q  <= '0;
            last_q  <= '0;
        end else begin
            timer_q <= timer_d;
            lock_q  <= lock_d;
            last_q  <= last_d;
        end
    end

    assign timer_o        = timer_q;
    assign host_present_o = (lock_q == LockMax);

endmodule

// File: rtl/boot_sequencer.sv
// Decides when to warm-boot (host request or host absence), waits out flash and USB traffic,
// then drives SB_WARMBOOT and the RGB status LED.
module boot_sequencer
    import boot_pkg::*;
#(
    parameter int unsigned PRESENCE_TIMEOUT_CYCLES = 48000000,
    parameter int unsigned SOF_GAP_CYCLES          = 72000,
    parameter int unsigned SOF_LOCK_COUNT          = 3,
    parameter int unsigned BOOT_DELAY_CYCLES       = 480000,
    parameter logic [1:0]  DEFAULT_IMAGE           = IMG_USER0,
    parameter int unsigned BLINK_BIT               = 23
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              sof_valid_i,
    input  logic [FrameW-1:0] frame_index_i,
    input  logic              boot_req_i,
    input  logic [1:0]        boot_image_i,
    input  logic              spi_busy_i,
    output logic              host_present_o,
    output logic              boot_pending_o,
    output logic              warmboot_s1_o,
    output logic              warmboot_s0_o,
    output logic              warmboot_boot_o,
    output logic [2:0]        rgb_pwm_o
);

    boot_state_e state_q, state_d;
    logic [1:0]  img_q, img_d;
    logic [31:0] delay_q, delay_d;
    logic [31:0] blink_q;
    logic [2:0]  rgb_q, rgb_d;
    logic [31:0] timer;
    logic        host_present;
    logic        timeout;

    sof_lock_detector #(
        .SOF_GAP_CYCLES (SOF_GAP_CYCLES),
        .SOF_LOCK_COUNT (SOF_LOCK_COUNT)
    ) u_sof_lock (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .sof_valid_i    (sof_valid_i),
        .frame_index_i  (frame_index_i),
        .timer_o        (timer),
        .host_present_o (host_present)
    );

    assign timeout = ((state_q == StWaitHost) || (state_q == StHostOk)) &&
                     (timer == PRESENCE_TIMEOUT_CYCLES);

    always_comb begin
        state_d = state_q;
        img_d   = img_q;
        delay_d = delay_q;
        rgb_d   = 3'b000;

        unique case (state_q)
            StWaitHost, StHostOk: begin
                // An explicit request beats a coincident timeout and supplies its own image.
                if (boot_req_i) begin
                    state_d = StArm;
                    img_d   = boot_image_i;
                    delay_d = BOOT_DELAY_CYCLES;
                end else if (timeout) begin
                    state_d = StArm;
                    img_d   = DEFAULT_IMAGE;
                    delay_d = BOOT_DELAY_CYCLES;
                end else if ((state_q == StWaitHost) && host_present) begin
                    state_d = StHostOk;
                end else if ((state_q == StHostOk) && !host_present) begin
                    state_d = StWaitHost;
                end
            end
            StArm: begin
                if (delay_q != '0) begin
                    delay_d = delay_q - 32'd1;
                end else if (!spi_busy_i) begin
                    state_d = StFire;
                end
            end
            StFire: begin
            end
            default: state_d = StWaitHost;
        endcase

        unique case (state_q)
            StWaitHost: rgb_d = {2'b00, blink_q[BLINK_BIT]};
            StHostOk:   rgb_d = 3'b010;
            default:    rgb_d = 3'b100;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StWaitHost;
            img_q   <= '0;
            delay_q <= '0;
            blink_q <= '0;
            rgb_q   <= 3'b001;
        end else begin
            state_q <= state_d;
            img_q   <= img_d;
            delay_q <= delay_d;
            blink_q <= blink_q + 32'd1;
            rgb_q   <= rgb_d;
        end
    end

    assign host_present_o  = host_present;
    assign boot_pending_o  = (state_q == StArm) || (state_q == StFire);
    assign warmboot_s1_o   = img_q[1];
    assign warmboot_s0_o   = img_q[0];
    assign warmboot_boot_o = (state_q == StFire);
    assign rgb_pwm_o       = rgb_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Drives directed and randomized SOF/request/busy traffic into boot_sequencer and compares
// every cycle against a timestamp-based model of the boot rules.
module tb_boot_sequencer;

    localparam int PT    = 1000;
    localparam int GAP   = 100;
    localparam int LOCK  = 3;
    localparam int DELAY = 20;
    localparam int BLINK = 4;
    localparam int DEF_IMG = 1;

    localparam int PhWait = 0;
    localparam int PhOk   = 1;
    localparam int PhArm  = 2;
    localparam int PhFire = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        sof_valid;
    logic [10:0] frame_index;
    logic        boot_req;
    logic [1:0]  boot_image;
    logic        spi_busy;
    logic        host_present, boot_pending, warmboot_s1, warmboot_s0, warmboot_boot;
    logic [2:0]  rgb_pwm;

    always #5 clk = ~clk;

    boot_sequencer #(
        .PRESENCE_TIMEOUT_CYCLES (PT),
        .SOF_GAP_CYCLES          (GAP),
        .SOF_LOCK_COUNT          (LOCK),
        .BOOT_DELAY_CYCLES       (DELAY),
        .DEFAULT_IMAGE           (2'b01),
        .BLINK_BIT               (BLINK)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset),
        .sof_valid_i     (sof_valid),
        .frame_index_i   (frame_index),
        .boot_req_i      (boot_req),
        .boot_image_i    (boot_image),
        .spi_busy_i      (spi_busy),
        .host_present_o  (host_present),
        .boot_pending_o  (boot_pending),
        .warmboot_s1_o   (warmboot_s1),
        .warmboot_s0_o   (warmboot_s0),
        .warmboot_boot_o (warmboot_boot),
        .rgb_pwm_o       (rgb_pwm)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: cycles are numbered from the first cycle after reset.
    int         m_now;
    int         m_sof_base;   // cycle at which the presence timer last read 0
    int         m_run;        // consecutive good SOFs, capped at LOCK
    int         m_last;
    int         m_phase;
    int         m_arm_cycle;
    int         m_img;
    logic [2:0] m_rgb;

    task automatic model_reset();
        m_now = 0; m_sof_base = 0; m_run = 0; m_last = 0;
        m_phase = PhWait; m_arm_cycle = 0; m_img = 0; m_rgb = 3'b001;
    endtask

    function automatic logic [7:0] model_vec();
        logic [1:0] img2;
        img2 = m_img[1:0];
        return {m_run == LOCK, m_phase >= PhArm, img2, m_phase == PhFire, m_rgb};
    endfunction

    task automatic model_step(input bit rst, input bit sof, input int fr, input bit req,
                              input int img, input bit busy);
        int timer;
        bit host, tout, good;
        if (rst) begin
            model_reset();
            return;
        end
        timer = m_now - m_sof_base;
        host  = (m_run == LOCK);
        tout  = (m_phase == PhWait || m_phase == PhOk) && (timer == PT);

        if (m_phase == PhWait)    m_rgb = {2'b00, 1'((m_now >> BLINK) & 1)};
        else if (m_phase == PhOk) m_rgb = 3'b010;
        else                      m_rgb = 3'b100;

        if (m_phase == PhWait || m_phase == PhOk) begin
            if (req || tout) begin
                m_phase     = PhArm;
                m_img       = req ? img : DEF_IMG;
                m_arm_cycle = m_now + 1;
            end else if (m_phase == PhWait && host) begin
                m_phase = PhOk;
            end else if (m_phase == PhOk && !host) begin
                m_phase = PhWait;
            end
        end else if (m_phase == PhArm) begin
            if ((m_now - m_arm_cycle) >= DELAY && !busy) m_phase = PhFire;
        end

        if (sof) begin
            good       = (timer <= GAP) && (fr == (m_last + 1) % 2048);
            m_run      = good ? ((m_run < LOCK) ? m_run + 1 : LOCK) : 1;
            m_last     = fr;
            m_sof_base = m_now + 1;
        end else if (timer > GAP) begin
            m_run = 0;
        end
        m_now++;
    endtask

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got {hp,pend,s1,s0,boot,rgb}=%b expected %b",
                     tag, m_now, obs, exp);
        end
    endtask

    // Compare current outputs, apply one cycle of inputs, advance model and DUT together.
    task automatic step(input string tag, input bit rst, input bit sof, input int fr,
                        input bit req, input int img, input bit busy);
        check_eq(tag, {host_present, boot_pending, warmboot_s1, warmboot_s0, warmboot_boot,
                       rgb_pwm}, model_vec());
        reset       = rst;
        sof_valid   = sof;
        frame_index = 11'(fr);
        boot_req    = req;
        boot_image  = 2'(img);
        spi_busy    = busy;
        model_step(rst, sof, fr, req, img, busy);
        @(posedge clk);
        #1;
    endtask

    task automatic run_episode(input string tag, input int period, input int first_frame,
                               input int skip_after, input int req_at, input int req_img,
                               input int req2_at, input int req2_img, input int busy_from,
                               input int busy_to, input int rst_at, input int len,
                               input bit rnd);
        int  fr, nsof, drop_lo, drop_hi, img;
        bit  sof, req, busy, rst;
        fr = first_frame; nsof = 0; busy = 1'b0;
        drop_lo = rnd ? int'($urandom_range(200, 2000)) : 0;
        drop_hi = rnd ? drop_lo + int'($urandom_range(0, 1500)) : 0;
        step({tag, "_rst"}, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
        for (int c = 0; c < len; c++) begin
            sof = (period > 0) && (c % period == period - 1) && !(c >= drop_lo && c < drop_hi);
            req = (c == req_at) || (c == req2_at);
            img = (c == req2_at) ? req2_img : req_img;
            rst = (c == rst_at);
            if (rnd) begin
                req  = ($urandom_range(0, 1499) == 0);
                img  = int'($urandom_range(0, 3));
                rst  = ($urandom_range(0, 3999) == 0);
                if ($urandom_range(0, 29) == 0) busy = !busy;
            end else begin
                busy = (c >= busy_from) && (c < busy_to);
            end
            step(tag, rst, sof, sof ? fr : int'($urandom_range(0, 2047)), req, img, busy);
            if (sof) begin
                nsof++;
                fr = (fr + 1) % 2048;
                if (nsof == skip_after || (rnd && $urandom_range(0, 7) == 0)) fr = (fr + 1) % 2048;
            end
        end
    endtask

    initial begin
        int periods[7] = '{50, 80, 95, 99, 100, 101, 130};
        reset = 1'b1; sof_valid = 1'b0; frame_index = '0;
        boot_req = 1'b0; boot_image = '0; spi_busy = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();

        // Host absent: default-image boot after the presence timeout.
        run_episode("timeout", 0, 0, -1, -1, 0, -1, 0, 0, 0, -1, 1100, 1'b0);
        // Lock across the 2047 -> 0 wrap, then stay locked with no boot.
        run_episode("lock_wrap", 80, 2046, -1, -1, 0, -1, 0, 0, 0, -1, 5000, 1'b0);
        // Frame skip 5 -> 7 drops lock; it re-locks two good SOFs later.
        run_episode("skip", 80, 3, 3, -1, 0, -1, 0, 0, 0, -1, 1200, 1'b0);
        // Request while flash busy: BOOT waits for spi_busy to fall.
        run_episode("busy", 0, 0, -1, 100, 2, -1, 0, 100, 150, -1, 300, 1'b0);
        // Request coincident with timeout wins; a second request in ARM is ignored.
        run_episode("req_tout", 0, 0, -1, 1000, 3, 1010, 0, 0, 0, -1, 1100, 1'b0);
        // Reset five cycles into ARM, then the timeout sequence restarts.
        run_episode("rst_arm", 0, 0, -1, -1, 0, -1, 0, 0, 0, 1006, 2200, 1'b0);

        for (int e = 0; e < 8; e++) begin
            run_episode("rand", periods[$urandom_range(0, 6)], int'($urandom_range(0, 2047)),
                        -1, -1, 0, -1, 0, 0, 0, -1, 3000, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
